layer_output_serializer: RTL and testbench
==========================================

LAYER_OUTPUT_SERIALIZER -- requirements
Module: layer_output_serializer

Interface
REQ-001 SHALL have parameter NUM_NEURON, default 30, number of neuron outputs per layer vector.
REQ-002 SHALL have parameter DATA_WIDTH, default `dataWidth, signed width of one neuron output.
REQ-003 SHALL have parameter LANES, default 1, neuron outputs per output beat; NUM_NEURON % LANES == 0, checked at elaboration.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port flush  input  1  synchronous clear of buffered vectors, active-high.
REQ-007 SHALL have port in_valid  input  1  layer vector present on in_data.
REQ-008 SHALL have port in_ready  output  1  block can accept a vector this cycle.
REQ-009 SHALL have port in_data  input  NUM_NEURON*DATA_WIDTH  layer vector; neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid beat.
REQ-011 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-012 SHALL have port out_data  output  LANES*DATA_WIDTH  beat; lane j carries neuron (beat*LANES + j).
REQ-013 SHALL have port out_last  output  1  final beat of a vector.
REQ-014 SHALL have port out_beat  output  $clog2(NUM_NEURON/LANES)  index of the current beat (min width 1).
REQ-015 SHALL have port vec_count  output  16  vectors fully sent since reset, wraps 0xFFFF->0.

Function
REQ-016 Input transfer SHALL occur on the edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-017 Block SHALL hold two vector buffers (ping/pong); in_ready = 1 whenever at least one buffer is free, independent of out_ready.
REQ-018 in_ready SHALL also be 1 when both buffers are full and the final beat of the active buffer transfers in the same cycle; accept and release both take effect.
REQ-019 Latency: vector accepted at edge N SHALL present beat 0 with out_valid=1 after edge N when no other vector is active.
REQ-020 Each vector SHALL produce exactly NUM_NEURON/LANES beats, beat order 0..last, no gaps while out_ready=1 (one beat per cycle).
REQ-021 out_last SHALL be 1 only on beat NUM_NEURON/LANES-1; out_beat SHALL equal the beat index.
REQ-022 While out_valid && !out_ready, out_data, out_last, out_beat SHALL remain stable.
REQ-023 After the final beat of buffer A, beat 0 of buffer B SHALL follow on the next cycle if B is full (back-to-back vectors, no bubble).
REQ-024 Vectors SHALL be emitted in acceptance order.
REQ-025 Control FSM states: EMPTY (no buffer full, out_valid=0), SEND (one full), SEND_FULL (two full, in_ready=0 unless REQ-018).
REQ-026 Transitions: EMPTY->SEND on input; SEND->SEND_FULL on input without last transfer; SEND->EMPTY on last transfer without input; SEND_FULL->SEND on last transfer without input; otherwise hold.
REQ-027 vec_count SHALL increment on each out_last transfer.
REQ-028 flush=1 SHALL empty both buffers, force EMPTY, out_valid=0, beat index 0 on next edge; input transfer that same cycle SHALL be discarded; vec_count unchanged.
REQ-029 Data SHALL pass bit-exact; no arithmetic on neuron values.

Reset
REQ-030 reset=0 SHALL asynchronously force EMPTY, out_valid=0, out_last=0, out_beat=0, out_data=0, vec_count=0, buffers cleared, in_ready=0 during reset.
REQ-031 in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-032 Reset mid-vector SHALL abandon the vector; no partial beats after release.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and beat-count helper function; DATA_WIDTH default stays in include.v.
REQ-034 One sub-module SHALL be natural: vector_buffer_slot (one ping/pong buffer with load, select-beat mux, full flag), instantiated twice.

Verification
REQ-035 NUM_NEURON=30,LANES=1, vector k=neuron value k, out_ready=1 -> 30 beats values 0..29, out_last on beat 29, vec_count=1.
REQ-036 LANES=5, out_ready toggled 1/0 each cycle -> 6 beats, each stable while stalled, lanes {0..4},{5..9}..., last on beat 5.
REQ-037 Three vectors offered back-to-back, out_ready=1 -> in_ready low only for third until first last-beat; 90 contiguous beats, order preserved.
REQ-038 flush asserted at beat 10 with second vector buffered -> out_valid=0 next cycle, in_ready=1, no further beats, vec_count unchanged.
REQ-039 reset=0 pulse asynchronous to clk at beat 7 -> outputs zero immediately, vec_count=0, new vector afterwards starts at beat 0.
REQ-040 vec_count preloaded path: 65536 vectors sent -> vec_count wraps to 0.

Source files
------------

// File: rtl/layer_output_serializer_pkg.sv
// Shared types and sizing helpers for the layer output serializer.
package layer_output_serializer_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StSend,
    StSendFull
  } ser_state_e;

  function automatic int unsigned beat_count(input int unsigned num_neuron,
                                             input int unsigned lanes);
    return num_neuron / lanes;
  endfunction

  // Beat index width, never narrower than one bit.
  function automatic int unsigned beat_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vector_buffer_slot.sv
// One ping/pong vector buffer: captures a whole layer vector and muxes out one beat.
module vector_buffer_slot
  import layer_output_serializer_pkg::*;
#(
  parameter int unsigned NUM_NEURON = 30,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clear,
  input  logic                                          load,
  input  logic                                          rel,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0]              load_data,
  input  logic [beat_width(beat_count(NUM_NEURON, LANES))-1:0] beat,
  output logic                                          full,
  output logic [LANES*DATA_WIDTH-1:0]                   beat_data
);

  localparam int unsigned NumBeats = beat_count(NUM_NEURON, LANES);

  logic [NumBeats-1:0][LANES*DATA_WIDTH-1:0] data_q;

  // A load in the same cycle as a release keeps the slot full with new data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      full   <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      data_q <= load_data;
      full   <= 1'b1;
    end else if (rel) begin
      full <= 1'b0;
    end
  end

  if (NumBeats == 1) begin : g_single
    logic unused_beat;
    assign unused_beat = ^beat;
    assign beat_data   = data_q[0];
  end else begin : g_mux
    assign beat_data = data_q[beat];
  end

endmodule

// File: rtl/layer_output_serializer.sv
// Serializes whole layer vectors into LANES-wide beats, double-buffered so
// the next vector can be captured while the current one drains.
`ifndef dataWidth
`define dataWidth 16
`endif

module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter int unsigned NUM_NEURON = 30,
  parameter int unsigned DATA_WIDTH = `dataWidth,
  parameter int unsigned LANES      = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0]              in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]                   out_data,
  output logic                                          out_last,
  output logic [beat_width(beat_count(NUM_NEURON, LANES))-1:0] out_beat,
  output logic [15:0]                                   vec_count
);

  localparam int unsigned NumBeats = beat_count(NUM_NEURON, LANES);
  localparam int unsigned BeatW    = beat_width(NumBeats);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

  if (NUM_NEURON % LANES != 0) begin : g_bad_lanes
    $error("NUM_NEURON must be a multiple of LANES");
  end

  ser_state_e             state_q, state_d;
  logic [BeatW-1:0]       beat_q;
  logic                   rd_sel_q, wr_sel_q, ready_q;
  logic                   last_beat, in_xfer, out_xfer, last_xfer;
  logic [1:0]             slot_load, slot_rel, slot_full;
  logic [LANES*DATA_WIDTH-1:0] slot_data [2];

  assign last_beat = (beat_q == LastBeat);
  assign out_xfer  = out_valid && out_ready;
  assign last_xfer = out_xfer && last_beat;
  // Both buffers full still accepts when the active one frees up this cycle.
  assign in_ready  = ready_q && ((state_q != StSendFull) || last_xfer);
  assign in_xfer   = in_valid && in_ready;

  assign out_last  = out_valid && last_beat;
  assign out_beat  = beat_q;
  assign out_data  = (out_valid && slot_full[rd_sel_q]) ? slot_data[rd_sel_q] : '0;

  assign slot_load = (in_xfer && !flush) ? (wr_sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign slot_rel  = (last_xfer && !flush) ? (rd_sel_q ? 2'b10 : 2'b01) : 2'b00;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    vector_buffer_slot #(
      .NUM_NEURON(NUM_NEURON),
      .DATA_WIDTH(DATA_WIDTH),
      .LANES     (LANES)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .load     (slot_load[i]),
      .rel      (slot_rel[i]),
      .load_data(in_data),
      .beat     (beat_q),
      .full     (slot_full[i]),
      .beat_data(slot_data[i])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty:    if (in_xfer) state_d = StSend;
      StSend: begin
        if (in_xfer && !last_xfer)      state_d = StSendFull;
        else if (last_xfer && !in_xfer) state_d = StEmpty;
      end
      StSendFull: if (last_xfer && !in_xfer) state_d = StSend;
      default:    state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StEmpty;
      out_valid <= 1'b0;
      beat_q    <= '0;
      rd_sel_q  <= 1'b0;
      wr_sel_q  <= 1'b0;
      ready_q   <= 1'b0;
      vec_count <= '0;
    end else begin
      ready_q <= 1'b1;
      if (flush) begin
        state_q   <= StEmpty;
        out_valid <= 1'b0;
        beat_q    <= '0;
        rd_sel_q  <= 1'b0;
        wr_sel_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        out_valid <= (state_d != StEmpty);
        if (out_xfer)  beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (in_xfer)   wr_sel_q <= ~wr_sel_q;
        if (last_xfer) begin
          rd_sel_q  <= ~rd_sel_q;
          vec_count <= vec_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for the layer output serializer: three configurations
// (30x1, 30x5 lanes, 4x4 lanes for the counter wrap).
module tb_layer_output_serializer;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  // A: 30 neurons, 1 lane
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [30*DW-1:0] a_in_data;
  logic [DW-1:0]    a_out_data;
  logic [4:0]       a_out_beat;
  logic [15:0]      a_vec_count;

  // B: 30 neurons, 5 lanes
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [30*DW-1:0] b_in_data;
  logic [5*DW-1:0]  b_out_data;
  logic [2:0]       b_out_beat;
  logic [15:0]      b_vec_count;

  // C: 4 neurons, 4 lanes of 8 bits -> one beat per vector
  logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic [31:0] c_in_data, c_out_data;
  logic [0:0]  c_out_beat;
  logic [15:0] c_vec_count;

  layer_output_serializer #(.NUM_NEURON(30), .DATA_WIDTH(DW), .LANES(1)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .out_beat(a_out_beat),
    .vec_count(a_vec_count)
  );

  layer_output_serializer #(.NUM_NEURON(30), .DATA_WIDTH(DW), .LANES(5)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .out_beat(b_out_beat),
    .vec_count(b_vec_count)
  );

  layer_output_serializer #(.NUM_NEURON(4), .DATA_WIDTH(8), .LANES(4)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_last(c_out_last), .out_beat(c_out_beat),
    .vec_count(c_vec_count)
  );

  typedef struct {
    logic in_valid;
    logic out_ready;
    logic flush;
    logic e_valid;
    logic e_last;
    logic e_in_ready;
    int   e_beat;
  } row_t;

  row_t tbl [15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30*DW-1:0] mk_vec(input int base);
    logic [30*DW-1:0] v;
    for (int k = 0; k < 30; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  function automatic logic [5*DW-1:0] b_beat(input int b);
    logic [5*DW-1:0] v;
    for (int j = 0; j < 5; j++) v[j*DW +: DW] = DW'(b * 5 + j);
    return v;
  endfunction

  initial begin
    int sent, got, first_c, last_c, vi, bi, cnt, done, prev;
    int acc [3];

    reset = 1'b0;
    {a_flush, a_in_valid, a_out_ready} = '0;
    {b_flush, b_in_valid, b_out_ready} = '0;
    {c_flush, c_in_valid, c_out_ready} = '0;
    a_in_data = '0;
    b_in_data = '0;
    c_in_data = '0;

    // Stall/toggle pattern for the 5-lane instance.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};

    // Reset state
    #2;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_vec_count", a_vec_count, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_beat", a_out_beat, 0);
    step();
    step();
    reset = 1'b1;
    #1;
    check("in_ready_before_edge", a_in_ready, 0);
    step();
    check("in_ready_after_edge", a_in_ready, 1);

    // 5-lane table
    b_in_data = mk_vec(0);
    for (int r = 0; r < 15; r++) begin
      b_in_valid  = tbl[r].in_valid;
      b_out_ready = tbl[r].out_ready;
      b_flush     = tbl[r].flush;
      #1;
      check($sformatf("b_valid[%0d]", r), b_out_valid, tbl[r].e_valid);
      check($sformatf("b_beat[%0d]", r), b_out_beat, tbl[r].e_beat);
      check($sformatf("b_last[%0d]", r), b_out_last, tbl[r].e_last);
      check($sformatf("b_in_ready[%0d]", r), b_in_ready, tbl[r].e_in_ready);
      if (tbl[r].e_valid) check($sformatf("b_data[%0d]", r), b_out_data, b_beat(tbl[r].e_beat));
      step();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b0;
    check("b_vec_count", b_vec_count, 1);

    // Single vector, 30 beats of 1 lane
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = mk_vec(0);
    step();
    a_in_valid = 1'b0;
    for (int b = 0; b < 30; b++) begin
      check($sformatf("a_valid[%0d]", b), a_out_valid, 1);
      check($sformatf("a_beat[%0d]", b), a_out_beat, b);
      check($sformatf("a_data[%0d]", b), a_out_data, b);
      check($sformatf("a_last[%0d]", b), a_out_last, (b == 29));
      step();
    end
    check("a_idle_after_vec", a_out_valid, 0);
    check("a_vec_count_1", a_vec_count, 1);

    // Three vectors offered back-to-back
    sent = 0; got = 0; first_c = -1; last_c = -1;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    for (int c = 0; c < 120; c++) begin
      if (a_out_valid) begin
        vi = got / 30;
        bi = got % 30;
        check($sformatf("b2b_data[%0d]", got), a_out_data, 100 * (vi + 1) + bi);
        check($sformatf("b2b_beat[%0d]", got), a_out_beat, bi);
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      a_in_valid = (sent < 3);
      a_in_data  = mk_vec(100 * (sent + 1));
      #1;
      if (a_in_valid && a_in_ready) begin
        acc[sent] = c;
        sent++;
      end
      step();
    end
    a_in_valid = 1'b0;
    check("b2b_acc0", acc[0], 0);
    check("b2b_acc1", acc[1], 1);
    check("b2b_acc2", acc[2], 30);
    check("b2b_first", first_c, 1);
    check("b2b_last", last_c, 90);
    check("b2b_count", got, 90);
    check("b2b_vec_count", a_vec_count, 4);

    // Flush at beat 10 with a second vector buffered
    a_in_valid = 1'b1;
    a_in_data  = mk_vec(500);
    step();
    a_in_data = mk_vec(600);
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 20 && a_out_beat != 5'd10; i++) step();
    check("flush_reach_beat10", a_out_beat, 10);
    a_flush    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = mk_vec(900);
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    check("flush_out_valid", a_out_valid, 0);
    check("flush_out_beat", a_out_beat, 0);
    check("flush_vec_count", a_vec_count, 4);
    #1;
    check("flush_in_ready", a_in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_out_valid) cnt++;
      step();
    end
    check("flush_no_beats", cnt, 0);

    // Asynchronous reset pulse at beat 7
    a_in_valid = 1'b1;
    a_in_data  = mk_vec(700);
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 20 && a_out_beat != 5'd7; i++) step();
    check("rst_reach_beat7", a_out_beat, 7);
    #3;
    reset = 1'b0;
    #1;
    check("arst_out_valid", a_out_valid, 0);
    check("arst_out_data", a_out_data, 0);
    check("arst_out_last", a_out_last, 0);
    check("arst_out_beat", a_out_beat, 0);
    check("arst_vec_count", a_vec_count, 0);
    check("arst_in_ready", a_in_ready, 0);
    #1;
    reset = 1'b1;
    step();
    a_in_valid = 1'b1;
    a_in_data  = mk_vec(800);
    #1;
    check("post_rst_in_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    check("post_rst_valid", a_out_valid, 1);
    check("post_rst_beat0", a_out_beat, 0);
    check("post_rst_data0", a_out_data, 800);
    step();
    check("post_rst_beat1", a_out_beat, 1);
    check("post_rst_data1", a_out_data, 801);
    a_out_ready = 1'b0;

    // vec_count wrap: one beat per vector, streamed continuously
    c_in_data   = 32'h0403_0201;
    c_in_valid  = 1'b1;
    c_out_ready = 1'b1;
    done = 0;
    prev = 0;
    for (int i = 0; i < 70000 && done < 65536; i++) begin
      if (c_out_valid && c_out_last) done++;
      if (done == 1 && prev == 0) check("wrap_data", c_out_data, 32'h0403_0201);
      step();
      if (done != prev) begin
        if (done == 1)     check("wrap_count_1", c_vec_count, 1);
        if (done == 65535) check("wrap_count_ffff", c_vec_count, 16'hFFFF);
        prev = done;
      end
    end
    c_in_valid = 1'b0;
    check("wrap_done", done, 65536);
    check("wrap_count_0", c_vec_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
